// File: rtl/timer_arbiter.sv
// timer_arbiter
//   Round-robin arbiter that time-shares a single external Timer among
//   NUM_REQ requesters. The winner's count is latched and handed to the
//   Timer. The winner then receives a one-cycle done pulse when its interval
//   completes.
//
// Parameters
//   COUNTER_BITS  width of every count field (default 8)
//   NUM_REQ       number of requesters, 2..8 (default 2)
//   ACK_TIMEOUT   START cycles allowed for the Timer to acknowledge the
//                 trigger; only used when TIMER_ARBITER_TIMEOUT_EN is defined
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   req            per-requester level request, held until its done pulse
//   req_count      packed counts, requester i at [i*COUNTER_BITS +: COUNTER_BITS]
//   grant          one-hot owner of the Timer, zero when idle (registered)
//   done           one-cycle completion pulse to the owner (registered)
//   timer_en       high whenever grant is non-zero
//   timer_count    count latched from the owner
//   timer_trigger  start request to the Timer
//   timer_done     Timer status: low while running, high when idle/expired
//   error          sticky start-timeout flag
//
// Configuration
//   TIMER_ARBITER_TIMEOUT_EN  when defined, START gives up after ACK_TIMEOUT
//                             cycles without acknowledge, sets error and
//                             still completes the interval. When undefined,
//                             START waits indefinitely and error is tied to 0.

module timer_arbiter #(
    parameter int unsigned COUNTER_BITS = 8,
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*COUNTER_BITS-1:0] req_count,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            timer_en,
    output logic [COUNTER_BITS-1:0]         timer_count,
    output logic                            timer_trigger,
    input  logic                            timer_done,
    output logic                            error
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [COUNTER_BITS-1:0] count_q, count_d;
    logic                    trigger_q, trigger_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_owner_q, last_owner_d;

    logic [COUNTER_BITS-1:0] req_counts [NUM_REQ];
    logic                    rr_found;
    logic [IDX_W-1:0]        rr_winner;

`ifdef TIMER_ARBITER_TIMEOUT_EN
    localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
    logic             error_q, error_d;
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_counts
        assign req_counts[g] = req_count[g*COUNTER_BITS +: COUNTER_BITS];
    end

    // (base + offset) mod NUM_REQ; the search starts just after the last owner.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int unsigned offset);
        return IDX_W'((32'(base) + offset) % NUM_REQ);
    endfunction

    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!rr_found && req[rr_index(last_owner_q, i)]) begin
                rr_found  = 1'b1;
                rr_winner = rr_index(last_owner_q, i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        count_d      = count_q;
        trigger_d    = trigger_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
`ifdef TIMER_ARBITER_TIMEOUT_EN
        ack_cnt_d    = ack_cnt_q;
        error_d      = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d            = '0;
                    grant_d[rr_winner] = 1'b1;
                    owner_d            = rr_winner;
                    count_d            = req_counts[rr_winner];
                    // Trigger rises with the grant unless the interval is empty.
                    trigger_d          = (req_counts[rr_winner] != '0);
                    state_d            = ST_START;
`ifdef TIMER_ARBITER_TIMEOUT_EN
                    ack_cnt_d          = '0;
`endif
                end
            end
            ST_START: begin
                if (count_q == '0) begin
                    trigger_d = 1'b0;
                    state_d   = ST_FINISH;
                end else if (!timer_done) begin
                    trigger_d = 1'b0;
                    state_d   = ST_RUN;
                end else begin
`ifdef TIMER_ARBITER_TIMEOUT_EN
                    if (ack_cnt_q == ACK_LAST) begin
                        error_d   = 1'b1;
                        trigger_d = 1'b0;
                        state_d   = ST_FINISH;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (timer_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d       = grant_q;
                grant_d      = '0;
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            count_q      <= '0;
            trigger_q    <= 1'b0;
            owner_q      <= '0;
            last_owner_q <= LAST_RESET;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            count_q      <= count_d;
            trigger_q    <= trigger_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

`ifdef TIMER_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
            error_q   <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign grant         = grant_q;
    assign done          = done_q;
    assign timer_en      = |grant_q;
    assign timer_count   = count_q;
    assign timer_trigger = trigger_q;

endmodule
